// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD minimum scanner: coordinate widths,
// scan FSM states and the {row, col} packing used on every position bus.
package sad_pkg;

    localparam logic [31:0] INIT_MIN  = 32'd100000;
    localparam int          COORD_W   = 6;
    localparam int          ROW_COL_W = 12;
    localparam int          SAD_W     = 32;
    localparam int          RES_CNT_W = 13;
    localparam int          OUT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [ROW_COL_W-1:0] pack_row_col(
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/sad_min_scanner_if.sv
// Request/result channel between the scanner (master) and the SAD cores (slave).
interface sad_min_scanner_if import sad_pkg::*;;

    logic                 req_valid;
    logic                 req_ready;
    logic [ROW_COL_W-1:0] req_row_col;
    logic                 res_valid;
    logic [SAD_W-1:0]     res_sad;

    modport master (
        output req_valid, req_row_col,
        input  req_ready, res_valid, res_sad
    );

    modport slave (
        input  req_valid, req_row_col,
        output req_ready, res_valid, res_sad
    );

endinterface

// File: rtl/sad_pos_fifo.sv
// Synchronous FIFO of issued positions; pairs each in-order SAD result with
// the candidate it was computed for.
module sad_pos_fifo import sad_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 push_i,
    input  logic [ROW_COL_W-1:0] data_i,
    input  logic                 pop_i,
    output logic [ROW_COL_W-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ROW_COL_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define valid entries.
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sad_min_scanner.sv
// Scans a ROWS x COLS search window, issues positions to the SAD cores and
// keeps the strict running minimum SAD with its position.
module sad_min_scanner import sad_pkg::*; #(
    parameter int          ROWS     = 16,
    parameter int          COLS     = 16,
    parameter int          MAX_OUT  = 8,
    parameter logic [31:0] INIT_MIN = sad_pkg::INIT_MIN
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    sad_min_scanner_if.master    bus,
    output logic [SAD_W-1:0]     min_out,
    output logic [ROW_COL_W-1:0] row_col_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [COORD_W-1:0]   LAST_ROW  = COORD_W'(ROWS - 1);
    localparam logic [COORD_W-1:0]   LAST_COL  = COORD_W'(COLS - 1);
    localparam logic [RES_CNT_W-1:0] LAST_RES  = RES_CNT_W'(ROWS * COLS - 1);
    localparam logic [OUT_W-1:0]     OUT_LIMIT = OUT_W'(MAX_OUT);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   row_q, row_d;
    logic [COORD_W-1:0]   col_q, col_d;
    logic                 all_issued_q, all_issued_d;
    logic [OUT_W-1:0]     outst_q, outst_d;
    logic [RES_CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [SAD_W-1:0]     min_q, min_d;
    logic [ROW_COL_W-1:0] rc_q, rc_d;
    logic                 req_valid_q, req_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 fire_req;
    logic                 take_res;
    logic                 last_res;
    logic [ROW_COL_W-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign fire_req = req_valid_q && bus.req_ready;
    assign take_res = bus.res_valid && (state_q == RUN) && (outst_q != '0);
    assign last_res = take_res && (res_cnt_q == LAST_RES);

    sad_pos_fifo #(.DEPTH(MAX_OUT)) u_pos_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push_i  (fire_req),
        .data_i  (pack_row_col(row_q, col_q)),
        .pop_i   (take_res),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb assigns its outputs a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)    state_d = RUN;
            RUN:        if (last_res) state_d = DONE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d      = (state_d == RUN);
        done_d      = (state_d == DONE) && (state_q == RUN);
        req_valid_d = (state_d == RUN) && !all_issued_d && (outst_d < OUT_LIMIT);
    end

    // Issue position, in-flight count and running minimum.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        all_issued_d = all_issued_q;
        outst_d      = outst_q;
        res_cnt_d    = res_cnt_q;
        min_d        = min_q;
        rc_d         = rc_q;
        if (state_q != RUN) begin
            if (start) begin
                row_d        = '0;
                col_d        = '0;
                all_issued_d = 1'b0;
                outst_d      = '0;
                res_cnt_d    = '0;
                min_d        = INIT_MIN;
                rc_d         = '0;
            end
        end else begin
            if (fire_req) begin
                if (col_q != LAST_COL) begin
                    col_d = col_q + 1'b1;
                end else if (row_q != LAST_ROW) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    all_issued_d = 1'b1;
                end
            end
            outst_d = outst_q + OUT_W'(fire_req) - OUT_W'(take_res);
            if (take_res) begin
                res_cnt_d = res_cnt_q + 1'b1;
                // Strict compare: a tie keeps the earlier position.
                if (bus.res_sad < min_q) begin
                    min_d = bus.res_sad;
                    rc_d  = fifo_head;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            row_q        <= '0;
            col_q        <= '0;
            all_issued_q <= 1'b0;
            outst_q      <= '0;
            res_cnt_q    <= '0;
            min_q        <= INIT_MIN;
            rc_q         <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            all_issued_q <= all_issued_d;
            outst_q      <= outst_d;
            res_cnt_q    <= res_cnt_d;
            min_q        <= min_d;
            rc_q         <= rc_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.req_valid   = req_valid_q;
    assign bus.req_row_col = pack_row_col(row_q, col_q);
    assign min_out         = min_q;
    assign row_col_out     = rc_q;
    assign busy            = busy_q;
    assign done            = done_q;

    a_stray_result: assert property (@(posedge Clk) disable iff (Rst)
        !(bus.res_valid && !take_res))
        else $warning("sad_min_scanner: res_valid with nothing outstanding ignored");

    a_fifo_tracks_outstanding: assert property (@(posedge Clk) disable iff (Rst)
        fifo_empty == (outst_q == '0));

    a_no_issue_when_full: assert property (@(posedge Clk) disable iff (Rst)
        !(fire_req && fifo_full));

endmodule

// File: tb/tb_sad_min_scanner.sv
// Self-checking bench for sad_min_scanner on a 2x2 window with MAX_OUT=2:
// table-driven scans plus hand-written outstanding-limit, reset and stray-event sequences.
module tb_sad_min_scanner;

    localparam int          ROWS     = 2;
    localparam int          COLS     = 2;
    localparam int          MAX_OUT  = 2;
    localparam int          NPOS     = ROWS * COLS;
    localparam logic [31:0] INIT_VAL = 32'd100000;
    localparam int          NV       = 5;

    typedef struct {
        logic [31:0] min;
        logic [11:0] rc;
    } exp_t;

    typedef struct {
        logic [3:0][31:0] sad;
        bit               toggle;
        bit               mid_start;
        logic [31:0]      exp_min;
        logic [11:0]      exp_rc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] min_out;
    logic [11:0] row_col_out;
    logic        busy;
    logic        done;

    sad_min_scanner_if bus ();

    sad_min_scanner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .start       (start),
        .bus         (bus),
        .min_out     (min_out),
        .row_col_out (row_col_out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_pass;
    int               n_total;
    int               issue_cnt;
    int               res_idx;
    bit               go_check;
    bit               stalled;
    bit               done_exp;
    logic [31:0]      m_min;
    logic [11:0]      m_rc;
    logic [3:0][31:0] cur_sad;
    logic [11:0]      pend_q [$];
    exp_t             exp_q  [$];
    vec_t             vecs   [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [11:0] exp_pos(input int k);
        logic [5:0] r;
        logic [5:0] c;
        r = 6'(k / COLS);
        c = 6'(k % COLS);
        return {r, c};
    endfunction

    function automatic vec_t mk(input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input bit tog, input bit mid,
                                input logic [31:0] emin, input logic [11:0] erc);
        vec_t v;
        v.sad       = {s3, s2, s1, s0};
        v.toggle    = tog;
        v.mid_start = mid;
        v.exp_min   = emin;
        v.exp_rc    = erc;
        return v;
    endfunction

    // One clock: compare what the last edge produced, then drive the next inputs.
    task automatic cycle(input bit rdy, input bit give, input bit st);
        exp_t        e;
        logic [11:0] pos;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("min_out", min_out, e.min);
            check("row_col_out", 32'(row_col_out), 32'(e.rc));
        end
        check("done", 32'(done), 32'(done_exp));
        if (done_exp) check("busy_at_done", 32'(busy), 32'd0);
        done_exp = 1'b0;
        if (go_check) begin
            check("busy_after_start", 32'(busy), 32'd1);
            check("req_valid_after_start", 32'(bus.req_valid), 32'd1);
            go_check = 1'b0;
        end
        if (stalled) begin
            check("stall_req_valid", 32'(bus.req_valid), 32'd1);
            check("stall_req_row_col", 32'(bus.req_row_col), 32'(exp_pos(issue_cnt)));
        end
        start         = st;
        bus.res_valid = 1'b0;
        if (give && pend_q.size() > 0 && res_idx < NPOS) begin
            pos           = pend_q.pop_front();
            bus.res_valid = 1'b1;
            bus.res_sad   = cur_sad[res_idx];
            if (cur_sad[res_idx] < m_min) begin
                m_min = cur_sad[res_idx];
                m_rc  = pos;
            end
            exp_q.push_back('{min: m_min, rc: m_rc});
            res_idx++;
            if (res_idx == NPOS) done_exp = 1'b1;
        end
        bus.req_ready = rdy;
        stalled = bus.req_valid && !rdy;
        if (bus.req_valid && rdy) begin
            check("issue_pos", 32'(bus.req_row_col), 32'(exp_pos(issue_cnt)));
            pend_q.push_back(exp_pos(issue_cnt));
            issue_cnt++;
        end
    endtask

    task automatic start_scan(input logic [3:0][31:0] s);
        cur_sad   = s;
        res_idx   = 0;
        issue_cnt = 0;
        m_min     = INIT_VAL;
        m_rc      = '0;
        pend_q.delete();
        cycle(1'b0, 1'b0, 1'b1);
        go_check = 1'b1;
    endtask

    task automatic drain(input bit toggle, input bit mid_start);
        int k = 0;
        while ((res_idx < NPOS || exp_q.size() > 0) && k < 200) begin
            cycle(toggle ? bit'(k % 2) : 1'b1, 1'b1, mid_start && k == 2);
            k++;
        end
        check("scan_results", 32'(res_idx), 32'(NPOS));
        check("scan_issues", 32'(issue_cnt), 32'(NPOS));
        check("scan_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        go_check = 1'b0;
        stalled  = 1'b0;
        done_exp = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_sad   = '0;

        vecs[0] = mk(32'd500, 32'd300, 32'd300, 32'd700, 1'b0, 1'b0, 32'd300, 12'h001);
        vecs[1] = mk(32'd100000, 32'd200000, 32'd100001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd100000, 12'h000);
        vecs[2] = mk(32'd9, 32'd7, 32'd7, 32'd3, 1'b1, 1'b0, 32'd3, 12'h041);
        vecs[3] = mk(32'd0, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0, 32'd0, 12'h000);
        vecs[4] = mk(32'd40, 32'd30, 32'd20, 32'd20, 1'b0, 1'b1, 32'd20, 12'h040);

        repeat (3) @(negedge clk);
        check("reset_min_out", min_out, INIT_VAL);
        check("reset_row_col_out", 32'(row_col_out), 32'd0);
        check("reset_req_valid", 32'(bus.req_valid), 32'd0);
        check("reset_req_row_col", 32'(bus.req_row_col), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_scan(vecs[i].sad);
            drain(vecs[i].toggle, vecs[i].mid_start);
            check("vec_min_out", min_out, vecs[i].exp_min);
            check("vec_row_col_out", 32'(row_col_out), 32'(vecs[i].exp_rc));
        end

        // Stray result while in DONE must not disturb the held result.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_sad   = 32'd1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("stray_done_min", min_out, 32'd20);
        check("stray_done_rc", 32'(row_col_out), 32'h040);
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_done", 32'(done), 32'd0);

        // Outstanding limit: two requests go out, then issue stalls until a result returns.
        start_scan({32'd40, 32'd30, 32'd20, 32'd10});
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        check("max_out_issued", 32'(issue_cnt), 32'd2);
        check("max_out_req_valid_low", 32'(bus.req_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("released_one_issue", 32'(issue_cnt), 32'd3);
        drain(1'b0, 1'b0);
        check("max_out_min", min_out, 32'd10);
        check("max_out_rc", 32'(row_col_out), 32'h000);

        // Reset mid-scan after two results.
        start_scan({32'd70, 32'd60, 32'd80, 32'd50});
        for (int k = 0; k < 50 && res_idx < 2; k++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("pre_reset_min", min_out, 32'd50);
        @(negedge clk);
        rst           = 1'b1;
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        start         = 1'b0;
        @(negedge clk);
        check("midreset_min_out", min_out, INIT_VAL);
        check("midreset_row_col_out", 32'(row_col_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_req_valid", 32'(bus.req_valid), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
        stalled  = 1'b0;
        done_exp = 1'b0;

        // Stray result while in IDLE is ignored.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_sad   = 32'd1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("stray_idle_min", min_out, INIT_VAL);
        check("stray_idle_rc", 32'(row_col_out), 32'd0);
        check("stray_idle_busy", 32'(busy), 32'd0);

        // Rescan after reset starts again from (0,0).
        start_scan({32'd90, 32'd80, 32'd70, 32'd60});
        drain(1'b0, 1'b0);
        check("rescan_min", min_out, 32'd60);
        check("rescan_rc", 32'(row_col_out), 32'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
